// File: rtl/zilla_div_pkg.sv
// Shared definitions for the Zilla divider scheduler and divider wrappers:
// FSM state encoding and the RISC-V M-extension divide/remainder opcodes.
package zilla_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // R-type encodings with rd/rs1/rs2 zeroed; the divider decodes funct7/funct3/opcode.
    localparam logic [31:0] OPC_DIV  = 32'h0200_4033;
    localparam logic [31:0] OPC_DIVU = 32'h0200_5033;
    localparam logic [31:0] OPC_REM  = 32'h0200_6033;
    localparam logic [31:0] OPC_REMU = 32'h0200_7033;
    localparam logic [31:0] OPC_MASK = 32'hFE00_707F;

endpackage

// File: rtl/zilla_div_scheduler_arbiter.sv
// Combinational rotate-priority arbiter: the first requester after last_owner
// (with wrap) wins; grant is one-hot or zero.
module zilla_rr_arbiter #(
    parameter int N    = 2,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last_owner,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx
);

    int   idx_s;
    logic found_s;
    logic take_s;

    // Scan offsets 1..N from last_owner and latch the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        take_s    = 1'b0;
        idx_s     = 0;
        for (int i = 1; i <= N; i++) begin
            idx_s = (int'(last_owner) + i) % N;
            for (int j = 0; j < N; j++) begin
                take_s    = req[j] && (j == idx_s) && !found_s;
                grant[j]  = grant[j] | take_s;
                grant_idx = take_s ? IDXW'(j) : grant_idx;
                found_s   = found_s | take_s;
            end
        end
    end

endmodule

// File: rtl/zilla_div_scheduler.sv
// Round-robin scheduler sharing one Zilla divider between NUM_REQ requesters,
// one outstanding request, with a completion watchdog.
module zilla_div_scheduler
    import zilla_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor_i,
    input  logic [NUM_REQ*32-1:0]         req_opcode_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          resp_err_o,
    output logic                          div_valid_o,
    output logic [31:0]                   div_opcode_o,
    output logic [DATA_WIDTH-1:0]         div_dividend_o,
    output logic [DATA_WIDTH-1:0]         div_divisor_o,
    input  logic                          div_valid_i,
    input  logic [DATA_WIDTH-1:0]         div_result_i,
    input  logic                          div_busy_i,
    output logic                          sched_busy_o
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT) + 1;

    logic [NUM_REQ-1:0]    grant_s;
    logic [IDXW-1:0]       grant_idx_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] sel_dividend_s;
    logic [DATA_WIDTH-1:0] sel_divisor_s;
    logic [31:0]           sel_opcode_s;

    sched_state_e          state_r;
    logic [IDXW-1:0]       owner_r;
    logic [IDXW-1:0]       last_owner_r;
    logic [CNTW-1:0]       cnt_r;
    logic                  div_valid_r;
    logic [31:0]           div_opcode_r;
    logic [DATA_WIDTH-1:0] div_dividend_r;
    logic [DATA_WIDTH-1:0] div_divisor_r;
    logic [NUM_REQ-1:0]    resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_data_r;
    logic                  resp_err_r;

    zilla_rr_arbiter #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_arb (
        .req        (req_valid_i),
        .last_owner (last_owner_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    // Accept strobe is combinational so the requester sees it in the grant cycle.
    always_comb begin
        accept_s = (state_r == IDLE) && !div_busy_i && (|req_valid_i);
        if (accept_s) begin
            req_ready_o = grant_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // One-hot AND-OR mux of the granted requester's operands and opcode.
    always_comb begin
        sel_dividend_s = '0;
        sel_divisor_s  = '0;
        sel_opcode_s   = 32'h0000_0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_dividend_s = sel_dividend_s | ({DATA_WIDTH{grant_s[k]}} & req_dividend_i[k*DATA_WIDTH +: DATA_WIDTH]);
            sel_divisor_s  = sel_divisor_s  | ({DATA_WIDTH{grant_s[k]}} & req_divisor_i[k*DATA_WIDTH +: DATA_WIDTH]);
            sel_opcode_s   = sel_opcode_s   | ({32{grant_s[k]}} & req_opcode_i[k*32 +: 32]);
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            owner_r        <= '0;
            last_owner_r   <= IDXW'(NUM_REQ - 1);
            cnt_r          <= '0;
            div_valid_r    <= 1'b0;
            div_opcode_r   <= 32'h0000_0000;
            div_dividend_r <= '0;
            div_divisor_r  <= '0;
            resp_valid_r   <= '0;
            resp_data_r    <= '0;
            resp_err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r        <= grant_idx_s;
                        div_opcode_r   <= sel_opcode_s;
                        div_dividend_r <= sel_dividend_s;
                        div_divisor_r  <= sel_divisor_s;
                        div_valid_r    <= 1'b1;
                        state_r        <= ISSUE;
                    end else begin
                        div_valid_r    <= 1'b0;
                    end
                end
                ISSUE: begin
                    div_valid_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    if (div_valid_i) begin
                        resp_data_r  <= div_result_i;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= NUM_REQ'(1) << owner_r;
                        state_r      <= RESP;
                    end else if (cnt_r == CNTW'(TIMEOUT - 1)) begin
                        resp_data_r  <= {DATA_WIDTH{1'b1}};
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= NUM_REQ'(1) << owner_r;
                        state_r      <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNTW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_i[owner_r]) begin
                        resp_valid_r <= '0;
                        last_owner_r <= owner_r;
                        state_r      <= IDLE;
                    end else begin
                        resp_valid_r <= resp_valid_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign div_valid_o    = div_valid_r;
    assign div_opcode_o   = div_opcode_r;
    assign div_dividend_o = div_dividend_r;
    assign div_divisor_o  = div_divisor_r;
    assign resp_valid_o   = resp_valid_r;
    assign resp_data_o    = resp_data_r;
    assign resp_err_o     = resp_err_r;
    assign sched_busy_o   = (state_r != IDLE);

endmodule

// File: tb/tb_zilla_div_scheduler.sv
// Directed self-checking bench for zilla_div_scheduler with a procedural divider model.
module tb_zilla_div_scheduler;
    import zilla_div_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 128;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
    logic [NR*DW-1:0]  req_dividend_i, req_divisor_i;
    logic [NR*32-1:0]  req_opcode_i;
    logic [DW-1:0]     resp_data_o;
    logic              resp_err_o, div_valid_o, div_valid_i, div_busy_i, sched_busy_o;
    logic [31:0]       div_opcode_o;
    logic [DW-1:0]     div_dividend_o, div_divisor_o, div_result_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    zilla_div_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i), .req_opcode_i(req_opcode_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_valid_i(div_valid_i), .div_result_i(div_result_i), .div_busy_i(div_busy_i),
        .sched_busy_o(sched_busy_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] dvd, input logic [DW-1:0] dvs, input logic [31:0] opc);
        req_dividend_i[k*DW +: DW] = dvd;
        req_divisor_i[k*DW +: DW]  = dvs;
        req_opcode_i[k*32 +: 32]   = opc;
    endtask

    // Called in the ISSUE cycle; divider answers lat cycles later, returns in the RESP cycle.
    task automatic finish_div(input int lat, input logic [DW-1:0] res);
        for (int i = 0; i < lat; i++) cyc();
        div_valid_i  = 1'b1;
        div_result_i = res;
        cyc();
        div_valid_i  = 1'b0;
        div_result_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = '0; resp_ready_i = '0; div_valid_i = 1'b0;
        div_result_i = '0; div_busy_i = 1'b0;
        req_dividend_i = '0; req_divisor_i = '0; req_opcode_i = '0;
        cyc(); cyc();
        rst_i = 1'b0;
        #1;
        n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 00", req_ready_o); end
        n_checks++; if (div_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_div_valid: got %b exp 0", div_valid_o); end
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b exp 00", resp_valid_o); end
        n_checks++; if (resp_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h exp 0", resp_data_o); end
        n_checks++; if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b exp 0", resp_err_o); end
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", sched_busy_o); end
        n_checks++; if (div_dividend_o !== 32'h0) begin n_fail++; $display("FAIL reset_dividend: got %h exp 0", div_dividend_o); end
        n_checks++; if (div_opcode_o !== 32'h0) begin n_fail++; $display("FAIL reset_opcode: got %h exp 0", div_opcode_o); end
    endtask

    task automatic test_single();
        set_req(0, 32'd100, 32'd7, OPC_DIVU);
        req_valid_i = 2'b01;
        #1;
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b exp 01", req_ready_o); end
        cyc();
        req_valid_i = 2'b00;
        #1;
        n_checks++; if (div_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b exp 1", div_valid_o); end
        n_checks++; if (div_dividend_o !== 32'd100) begin n_fail++; $display("FAIL single_dividend: got %0d exp 100", div_dividend_o); end
        n_checks++; if (div_divisor_o !== 32'd7) begin n_fail++; $display("FAIL single_divisor: got %0d exp 7", div_divisor_o); end
        n_checks++; if (div_opcode_o !== OPC_DIVU) begin n_fail++; $display("FAIL single_opcode: got %h exp %h", div_opcode_o, OPC_DIVU); end
        cyc();
        n_checks++; if (div_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_issue_pulse: got %b exp 0", div_valid_o); end
        finish_div(33, 32'd14);
        resp_ready_i = 2'b01;
        #1;
        n_checks++; if (resp_valid_o !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b exp 01", resp_valid_o); end
        n_checks++; if (resp_data_o !== 32'd14) begin n_fail++; $display("FAIL single_resp_data: got %0d exp 14", resp_data_o); end
        n_checks++; if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL single_resp_err: got %b exp 0", resp_err_o); end
        n_checks++; if (div_dividend_o !== 32'd100) begin n_fail++; $display("FAIL single_operand_hold: got %0d exp 100", div_dividend_o); end
        cyc();
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL single_resp_clear: got %b exp 00", resp_valid_o); end
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b exp 0", sched_busy_o); end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp_g;
        logic [31:0]   exp_opc;
        logic [DW-1:0] exp_res;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        set_req(0, 32'd100, 32'd7, OPC_REM);
        set_req(1, 32'd100, 32'd7, OPC_DIV);
        req_valid_i  = 2'b11;
        resp_ready_i = 2'b11;
        for (int r = 0; r < 4; r++) begin
            exp_g   = (r % 2 == 0) ? 2'b01 : 2'b10;
            exp_opc = (r % 2 == 0) ? OPC_REM : OPC_DIV;
            exp_res = (r % 2 == 0) ? 32'd2 : 32'd14;
            #1;
            n_checks++; if (req_ready_o !== exp_g) begin n_fail++; $display("FAIL fair_grant_%0d: got %b exp %b", r, req_ready_o, exp_g); end
            cyc();
            n_checks++; if (div_opcode_o !== exp_opc) begin n_fail++; $display("FAIL fair_opcode_%0d: got %h exp %h", r, div_opcode_o, exp_opc); end
            finish_div(3, exp_res);
            #1;
            n_checks++; if (resp_valid_o !== exp_g) begin n_fail++; $display("FAIL fair_owner_%0d: got %b exp %b", r, resp_valid_o, exp_g); end
            n_checks++; if (resp_data_o !== exp_res) begin n_fail++; $display("FAIL fair_data_%0d: got %0d exp %0d", r, resp_data_o, exp_res); end
            n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL fair_no_grant_%0d: got %b exp 00", r, req_ready_o); end
            cyc();
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_back_to_back_backpressure();
        set_req(0, 32'd100, 32'd7, OPC_REM);
        set_req(1, 32'd100, 32'd7, OPC_DIV);
        req_valid_i  = 2'b10;
        resp_ready_i = 2'b01;
        #1;
        n_checks++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b exp 10", req_ready_o); end
        cyc();
        req_valid_i = 2'b00;
        finish_div(2, 32'd14);
        for (int c = 0; c < 10; c++) begin
            req_valid_i = 2'b11;
            #1;
            n_checks++; if (resp_valid_o !== 2'b10) begin n_fail++; $display("FAIL bp_valid_%0d: got %b exp 10", c, resp_valid_o); end
            n_checks++; if (resp_data_o !== 32'd14) begin n_fail++; $display("FAIL bp_data_%0d: got %0d exp 14", c, resp_data_o); end
            n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_no_grant_%0d: got %b exp 00", c, req_ready_o); end
            cyc();
        end
        resp_ready_i = 2'b11;
        cyc();
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL bp_release: got %b exp 00", resp_valid_o); end
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL bp_next_grant: got %b exp 01", req_ready_o); end
        req_valid_i = 2'b00;
        cyc();
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b exp 0", sched_busy_o); end
    endtask

    task automatic test_timeout();
        int  cnt;
        logic seen;
        set_req(0, 32'd9, 32'd3, OPC_DIV);
        req_valid_i  = 2'b01;
        resp_ready_i = 2'b00;
        #1;
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL to_grant: got %b exp 01", req_ready_o); end
        cyc();
        req_valid_i = 2'b00;
        n_checks++; if (div_valid_o !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b exp 1", div_valid_o); end
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < TO + 20) begin
            cyc();
            cnt++;
            if (resp_valid_o !== 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_seen: got %b exp 1 after %0d cycles", seen, cnt); end
        n_checks++; if (cnt != TO + 1) begin n_fail++; $display("FAIL to_latency: got %0d exp %0d", cnt, TO + 1); end
        n_checks++; if (resp_valid_o !== 2'b01) begin n_fail++; $display("FAIL to_owner: got %b exp 01", resp_valid_o); end
        n_checks++; if (resp_data_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_data: got %h exp ffffffff", resp_data_o); end
        n_checks++; if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b exp 1", resp_err_o); end
        resp_ready_i = 2'b01;
        cyc();
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b exp 0", sched_busy_o); end
    endtask

    task automatic test_busy_stray();
        div_busy_i  = 1'b1;
        req_valid_i = 2'b01;
        #1;
        n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL busy_no_grant: got %b exp 00", req_ready_o); end
        cyc();
        n_checks++; if (div_valid_o !== 1'b0) begin n_fail++; $display("FAIL busy_no_issue: got %b exp 0", div_valid_o); end
        div_valid_i  = 1'b1;
        div_result_i = 32'd123;
        cyc();
        div_valid_i  = 1'b0;
        div_result_i = '0;
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL stray_no_resp: got %b exp 00", resp_valid_o); end
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL stray_idle: got %b exp 0", sched_busy_o); end
        div_busy_i = 1'b0;
        #1;
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL unbusy_grant: got %b exp 01", req_ready_o); end
        req_valid_i = 2'b00;
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        set_req(1, 32'd200, 32'd3, OPC_DIVU);
        req_valid_i = 2'b10;
        #1;
        n_checks++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL rmw_grant: got %b exp 10", req_ready_o); end
        cyc();
        req_valid_i = 2'b00;
        cyc(); cyc(); cyc();
        n_checks++; if (sched_busy_o !== 1'b1) begin n_fail++; $display("FAIL rmw_busy: got %b exp 1", sched_busy_o); end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        n_checks++; if (sched_busy_o !== 1'b0) begin n_fail++; $display("FAIL rmw_state: got %b exp 0", sched_busy_o); end
        n_checks++; if (div_dividend_o !== 32'h0) begin n_fail++; $display("FAIL rmw_dividend: got %h exp 0", div_dividend_o); end
        n_checks++; if (div_opcode_o !== 32'h0) begin n_fail++; $display("FAIL rmw_opcode: got %h exp 0", div_opcode_o); end
        div_valid_i  = 1'b1;
        div_result_i = 32'd55;
        cyc();
        div_valid_i  = 1'b0;
        div_result_i = '0;
        n_checks++; if (resp_valid_o !== 2'b00) begin n_fail++; $display("FAIL rmw_late_valid: got %b exp 00", resp_valid_o); end
        n_checks++; if (resp_data_o !== 32'h0) begin n_fail++; $display("FAIL rmw_late_data: got %h exp 0", resp_data_o); end
        req_valid_i = 2'b11;
        #1;
        n_checks++; if (req_ready_o !== 2'b01) begin n_fail++; $display("FAIL rmw_req0_first: got %b exp 01", req_ready_o); end
        req_valid_i = 2'b00;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back_backpressure();
        test_timeout();
        test_busy_stray();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
